// File: rtl/pito_test_pkg.sv
// Shared types and tohost encoding for the pito test monitor.
// A tohost write with bit 0 set is a report: value 1 is a pass, any other odd value is a fail.
package pito_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] TOHOST_PASS = 32'd1;

  // Index width that stays legal for a single-hart build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pito_hart_report.sv
// One hart's report latch: remembers that the hart reported, and whether that report was a fail.
// Only the first report of a run is kept; clear starts a new run.
module pito_hart_report
  import pito_test_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic wr,
  input  logic fail,
  output logic done_bit,
  output logic fail_bit
);

  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_bit <= 1'b0;
      fail_bit <= 1'b0;
    end else if (clear) begin
      done_bit <= 1'b0;
      fail_bit <= 1'b0;
    end else if (wr && !done_bit) begin
      done_bit <= 1'b1;
      fail_bit <= fail;
    end
  end

endmodule

// File: rtl/pito_test_monitor.sv
// Test-run monitor: collects per-hart tohost pass/fail reports, bounds the run by a cycle budget,
// and holds the verdict in DONE until the next start.
module pito_test_monitor
  import pito_test_pkg::*;
#(
  parameter int NUM_HARTS      = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 32,
  localparam int HART_W        = idx_w(NUM_HARTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_HARTS-1:0] hart_en,
  input  logic                 tohost_valid,
  input  logic [HART_W-1:0]    tohost_hart,
  input  logic [31:0]          tohost_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [NUM_HARTS-1:0] done_mask,
  output logic [NUM_HARTS-1:0] fail_mask,
  output logic [HART_W-1:0]    first_fail_hart,
  output logic [30:0]          first_fail_code,
  output logic [CNT_W-1:0]     cycle_count
);

  state_t               state, state_next;
  logic [NUM_HARTS-1:0] en_lat;
  logic [NUM_HARTS-1:0] wr_vec;
  logic [NUM_HARTS-1:0] done_next, fail_next;
  logic                 in_run, accept_start, hart_ok, report, is_fail;
  logic                 complete, timeout_hit;

  assign in_run       = (state == ST_RUN);
  assign accept_start = start && !in_run;
  assign hart_ok      = ({1'b0, tohost_hart} < (HART_W+1)'(NUM_HARTS));
  assign report       = in_run && tohost_valid && hart_ok && tohost_data[0];
  assign is_fail      = (tohost_data != TOHOST_PASS);

  for (genvar i = 0; i < NUM_HARTS; i++) begin : g_hart
    assign wr_vec[i] = report && (tohost_hart == HART_W'(i)) && en_lat[i] && !done_mask[i];

    pito_hart_report u_report (
      .clk      (clk),
      .rst      (rst),
      .clear    (accept_start),
      .wr       (wr_vec[i]),
      .fail     (is_fail),
      .done_bit (done_mask[i]),
      .fail_bit (fail_mask[i])
    );
  end

  // Masks as they will stand after this edge, so a completing write ends the run this cycle.
  assign done_next = done_mask | wr_vec;
  assign fail_next = fail_mask | (is_fail ? wr_vec : '0);

  // NOTE: every combinational output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        complete    = (done_next == en_lat);
        timeout_hit = !complete && (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
        if (complete || timeout_hit) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_RUN);
      done  <= (state_next == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_lat          <= '0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      first_fail_hart <= '0;
      first_fail_code <= '0;
      cycle_count     <= '0;
    end else if (accept_start) begin
      en_lat          <= hart_en;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      first_fail_hart <= '0;
      first_fail_code <= '0;
      cycle_count     <= '0;
    end else if (in_run) begin
      // The timeout cycle leaves the count at the budget limit.
      if (!timeout_hit) cycle_count <= cycle_count + CNT_W'(1);
      if (timeout_hit) timeout <= 1'b1;
      if (|wr_vec && is_fail && fail_mask == '0) begin
        first_fail_hart <= tohost_hart;
        first_fail_code <= tohost_data[31:1];
      end
      if (complete || timeout_hit) pass <= complete && (fail_next == '0);
    end
  end

endmodule

// File: tb/tb_pito_test_monitor.sv
// Directed bench for pito_test_monitor: pass, fail, timeout, boundary completion,
// ignored writes, empty enable set, and mid-run reset.
module tb_pito_test_monitor;

  localparam int NH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NH-1:0] hart_en = '0;
  logic          tohost_valid = 1'b0;
  logic [2:0]    tohost_hart = '0;
  logic [31:0]   tohost_data = '0;
  logic          busy, done, pass, timeout;
  logic [NH-1:0] done_mask, fail_mask;
  logic [2:0]    first_fail_hart;
  logic [30:0]   first_fail_code;
  logic [31:0]   cycle_count;

  int errors = 0;
  int checks = 0;

  pito_test_monitor #(.NUM_HARTS(NH), .TIMEOUT_CYCLES(100), .CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .hart_en         (hart_en),
    .tohost_valid    (tohost_valid),
    .tohost_hart     (tohost_hart),
    .tohost_data     (tohost_data),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .timeout         (timeout),
    .done_mask       (done_mask),
    .fail_mask       (fail_mask),
    .first_fail_hart (first_fail_hart),
    .first_fail_code (first_fail_code),
    .cycle_count     (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [NH-1:0] en);
    start   = 1'b1;
    hart_en = en;
    @(negedge clk);
    start   = 1'b0;
    hart_en = '0;
  endtask

  task automatic write(input int h, input logic [31:0] d);
    tohost_valid = 1'b1;
    tohost_hart  = 3'(h);
    tohost_data  = d;
    @(negedge clk);
    tohost_valid = 1'b0;
    tohost_data  = '0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cycle_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // All harts pass at counts 10..17
    do_start(8'hFF);
    check("t1_busy", busy, 1);
    check("t1_cnt0", cycle_count, 0);
    idle(10);
    for (int h = 0; h < NH; h++) write(h, 32'd1);
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_mask", done_mask, 8'hFF);
    check("t1_cnt", cycle_count, 18);
    idle(3);
    check("t1_hold_cnt", cycle_count, 18);

    // Two fails; the first one is recorded
    do_start(8'hFF);
    check("t2_clear", done_mask, 0);
    write(3, 32'h0000000B);
    for (int h = 0; h < 3; h++) write(h, 32'd1);
    write(4, 32'd1);
    write(5, 32'h7);
    check("t2_ffh_mid", first_fail_hart, 3);
    write(6, 32'd1);
    write(7, 32'd1);
    check("t2_done", done, 1);
    check("t2_pass", pass, 0);
    check("t2_fail", fail_mask, 8'h28);
    check("t2_ffh", first_fail_hart, 3);
    check("t2_ffc", first_fail_code, 5);
    check("t2_to", timeout, 0);

    // Hart 0 silent: timeout
    do_start(8'hFF);
    check("t3_clear_ff", first_fail_code, 0);
    for (int h = 1; h < NH; h++) write(h, 32'd1);
    wait_done(200);
    check("t3_done", done, 1);
    check("t3_to", timeout, 1);
    check("t3_pass", pass, 0);
    check("t3_cnt", cycle_count, 99);
    check("t3_mask", done_mask, 8'hFE);

    // Last hart completes exactly on the budget cycle
    do_start(8'hFF);
    for (int h = 0; h < 7; h++) write(h, 32'd1);
    idle(92);
    check("t4_cnt99", cycle_count, 99);
    check("t4_busy", busy, 1);
    write(7, 32'd1);
    check("t4_done", done, 1);
    check("t4_to", timeout, 0);
    check("t4_pass", pass, 1);
    check("t4_cnt", cycle_count, 100);

    // Ignored writes and a start while running
    do_start(8'h01);
    write(2, 32'd3);
    write(0, 32'd2);
    check("t5_busy", busy, 1);
    check("t5_mask0", done_mask, 0);
    start   = 1'b1;
    hart_en = 8'hFF;
    @(negedge clk);
    start   = 1'b0;
    hart_en = '0;
    write(0, 32'd1);
    write(0, 32'd3);
    check("t5_done", done, 1);
    check("t5_fail", fail_mask, 0);
    check("t5_mask", done_mask, 8'h01);
    check("t5_pass", pass, 1);
    check("t5_cnt", cycle_count, 4);

    // Nothing enabled: one RUN cycle then pass
    do_start(8'h00);
    check("t6_busy", busy, 1);
    @(negedge clk);
    check("t6_done", done, 1);
    check("t6_pass", pass, 1);
    check("t6_cnt", cycle_count, 1);

    // Reset mid-run with a report pending
    do_start(8'hFF);
    for (int h = 0; h < 4; h++) write(h, 32'd1);
    check("t7_mask", done_mask, 8'h0F);
    #2;
    rst          = 1'b1;
    tohost_valid = 1'b1;
    tohost_hart  = 3'd4;
    tohost_data  = 32'd1;
    #1;
    check("t7_async_mask", done_mask, 0);
    check("t7_async_busy", busy, 0);
    @(negedge clk);
    tohost_valid = 1'b0;
    check("t7_rst_mask", done_mask, 0);
    check("t7_rst_cnt", cycle_count, 0);
    check("t7_rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t7_idle", busy, 0);
    do_start(8'hFF);
    for (int h = 0; h < NH; h++) write(h, 32'd1);
    check("t7_done", done, 1);
    check("t7_pass", pass, 1);
    check("t7_fail", fail_mask, 0);
    check("t7_cnt", cycle_count, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pito_test_monitor.md
PITO_TEST_MONITOR -- requirements
Module: pito_test_monitor

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 8, number of harts monitored.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, run-cycle budget before timeout (min 2).
REQ-003 SHALL have parameter CNT_W, default 32, cycle counter width (2**CNT_W > TIMEOUT_CYCLES).
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  in  1  single-cycle pulse beginning a test run.
REQ-007 SHALL have port hart_en  in  NUM_HARTS  harts expected to report, sampled on accepted start.
REQ-008 SHALL have port tohost_valid  in  1  tohost write strobe.
REQ-009 SHALL have port tohost_hart  in  $clog2(NUM_HARTS)  writing hart index.
REQ-010 SHALL have port tohost_data  in  32  written value.
REQ-011 SHALL have port busy  out  1  state is RUN.
REQ-012 SHALL have port done  out  1  state is DONE.
REQ-013 SHALL have port pass  out  1  DONE, no timeout, fail_mask zero.
REQ-014 SHALL have port timeout  out  1  run ended by cycle budget.
REQ-015 SHALL have port done_mask / fail_mask  out  NUM_HARTS each  per-hart reported / reported-fail.
REQ-016 SHALL have port first_fail_hart  out  $clog2(NUM_HARTS), first_fail_code  out  31  first failing report.
REQ-017 SHALL have port cycle_count  out  CNT_W  cycles spent in RUN.

Function
REQ-018 SHALL implement FSM IDLE, RUN, DONE; start in IDLE or DONE -> RUN next cycle; start in RUN ignored.
REQ-019 On accepted start SHALL clear done_mask, fail_mask, timeout, first_fail_*, cycle_count, and latch hart_en.
REQ-020 In RUN cycle_count SHALL increment by 1 per cycle; frozen in IDLE/DONE.
REQ-021 tohost write SHALL be accepted only in RUN, only if latched hart_en[tohost_hart] set and done_mask bit clear; later writes from that hart ignored.
REQ-022 tohost_data == 1 SHALL set done_mask bit (pass); odd value != 1 SHALL set done_mask and fail_mask bits; even value (incl. 0) SHALL be ignored.
REQ-023 First accepted fail of a run SHALL load first_fail_hart and first_fail_code = tohost_data[31:1]; later fails SHALL not overwrite.
REQ-024 tohost_hart >= NUM_HARTS SHALL be ignored.
REQ-025 RUN -> DONE the cycle after done_mask (including the write accepted that cycle) covers latched hart_en.
REQ-026 Latched hart_en all zero SHALL go RUN -> DONE after one RUN cycle, pass=1.
REQ-027 When cycle_count == TIMEOUT_CYCLES-1 in RUN and completion not reached, SHALL set timeout and go DONE; completion in same cycle wins (timeout=0).
REQ-028 Outputs SHALL be registered; DONE holds all results until next accepted start.

Reset
REQ-029 rst asserted SHALL asynchronously force IDLE and zero every output and internal register, including mid-RUN; no report captured in reset cycle.
REQ-030 After rst deasserts, first start SHALL be accepted normally.

Structure
REQ-031 FSM state enum and tohost encoding constants (TOHOST_PASS=1) SHALL live in shared package pito_test_pkg.
REQ-032 Per-hart report latch (done/fail bit) SHALL be one sub-module pito_hart_report, instanced NUM_HARTS times via generate.
REQ-033 No delays, $finish or file I/O inside RTL; bench reacts to done.

Verification
REQ-034 NUM_HARTS=8, hart_en=0xFF, each hart writes 1 at cycles 10..17 -> done=1, pass=1, done_mask=0xFF, cycle_count=18.
REQ-035 hart 3 writes 0x0000000B, hart 5 writes 0x7 later, rest 1 -> pass=0, fail_mask=0x28, first_fail_hart=3, first_fail_code=5.
REQ-036 TIMEOUT_CYCLES=100, hart 0 never writes -> timeout=1, pass=0, cycle_count=99, done_mask=0xFE.
REQ-037 Last hart writes 1 on cycle_count==TIMEOUT_CYCLES-1 -> timeout=0, pass=1.
REQ-038 hart_en=0x01, hart 2 writes 3, hart 0 writes 2 then 1, hart 0 writes 3 after -> fail_mask=0, done_mask=0x01, pass=1.
REQ-039 rst pulsed mid-RUN with done_mask=0x0F -> all outputs 0, state IDLE; new start runs clean to pass.
